// File: rtl/decoder_nxm_scan.sv
// Registered N-to-2^N one-hot decoder: direct (handshaked select) or scan (dwell-timed walk).
// Optional break-before-make blank cycle per scan step: define DECODER_SCAN_BLANK_EN.
//
// state | meaning
// IDLE  | outputs inactive, waiting for a transfer or scan request
// HOLD  | D drives onehot(IDX) loaded by the last transfer or frozen from scan
// SCAN  | IDX advances every DWELL+1 cycles, wrapping modulo 2^N
module decoder_nxm_scan #(
  parameter int N          = 3,
  parameter int DWELL_W    = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 MODE,
  input  logic [N-1:0]         SEL,
  input  logic                 SEL_VALID,
  output logic                 SEL_READY,
  input  logic [DWELL_W-1:0]   DWELL,
  output logic [(2**N)-1:0]    D,
  output logic [N-1:0]         IDX,
  output logic                 WRAP,
  output logic                 BUSY
);

  localparam int W = 2 ** N;
  localparam logic [N-1:0] IDX_MAX = '1;

  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

  state_t             state;
  logic [W-1:0]       dAct;
  logic [N-1:0]       idx;
  logic [N-1:0]       idxNext;
  logic [DWELL_W-1:0] dwellCnt;
  logic               wrap;
  logic               xfer;
`ifdef DECODER_SCAN_BLANK_EN
  logic               blank;
`endif

  function automatic logic [W-1:0] oneHot(input logic [N-1:0] i);
    logic [W-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign SEL_READY = EN && !MODE && (state != SCAN);
  assign xfer      = SEL_VALID && SEL_READY;
  assign idxNext   = idx + N'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      dAct     <= '0;
      idx      <= '0;
      dwellCnt <= '0;
      wrap     <= 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
      blank    <= 1'b0;
`endif
    end else if (!EN) begin
      // idx deliberately kept so a re-enable can resume from the same line
      state    <= IDLE;
      dAct     <= '0;
      dwellCnt <= '0;
      wrap     <= 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
      blank    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          wrap <= 1'b0;
          if (MODE) begin
            state    <= SCAN;
            idx      <= '0;
            dAct     <= oneHot('0);
            dwellCnt <= DWELL;
          end else if (xfer) begin
            state <= HOLD;
            idx   <= SEL;
            dAct  <= oneHot(SEL);
          end
        end
        HOLD: begin
          wrap <= 1'b0;
          if (MODE) begin
            state    <= SCAN;
            dAct     <= oneHot(idx);
            dwellCnt <= DWELL;
          end else if (xfer) begin
            idx  <= SEL;
            dAct <= oneHot(SEL);
          end
        end
        SCAN: begin
          if (!MODE) begin
            state    <= HOLD;
            dAct     <= oneHot(idx);
            dwellCnt <= '0;
            wrap     <= 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
            blank    <= 1'b0;
`endif
          end else begin
`ifdef DECODER_SCAN_BLANK_EN
            // idx moves first with D dark for one cycle, then the new line lights
            if (blank) begin
              blank    <= 1'b0;
              dAct     <= oneHot(idx);
              dwellCnt <= DWELL;
              wrap     <= 1'b0;
            end else if (dwellCnt == '0) begin
              blank <= 1'b1;
              idx   <= idxNext;
              dAct  <= '0;
              wrap  <= (idx == IDX_MAX);
            end else begin
              dwellCnt <= dwellCnt - DWELL_W'(1);
              wrap     <= 1'b0;
            end
`else
            if (dwellCnt == '0) begin
              idx      <= idxNext;
              dAct     <= oneHot(idxNext);
              dwellCnt <= DWELL;
              wrap     <= (idx == IDX_MAX);
            end else begin
              dwellCnt <= dwellCnt - DWELL_W'(1);
              wrap     <= 1'b0;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign D    = (ACTIVE_LOW != 0) ? ~dAct : dAct;
  assign IDX  = idx;
  assign WRAP = wrap;
  assign BUSY = (state == SCAN);

endmodule

// File: doc/decoder_nxm_scan.md
Name: decoder_nxm_scan

Overview:
Parametrised, registered N-to-2^N one-hot decoder with enable and two modes.
- Direct mode: a select value is loaded through a valid/ready handshake and held on the outputs.
- Scan mode: an internal counter walks the active output across all 2^N lines with a programmable dwell time.
- Drives row/digit-select lines, e.g. multiplexed display or memory bank enables, downstream of control logic.

Parameters:
N, 3, select width; output width is 2**N.
DWELL_W, 8, width of dwell-time input and internal dwell counter.
ACTIVE_LOW, 0, 1 = asserted output bit is 0 and inactive lines are 1.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  asynchronous, active-high reset.
EN  input  1  block enable; 0 forces all outputs inactive.
MODE  input  1  0 = direct, 1 = scan.
SEL  input  N  select value, direct mode.
SEL_VALID  input  1  SEL valid.
SEL_READY  output  1  block accepts SEL this cycle.
DWELL  input  DWELL_W  each scan position is held DWELL+1 cycles.
D  output  2**N  registered one-hot (or one-cold) decode output.
IDX  output  N  index currently driven on D.
WRAP  output  1  one-cycle pulse when scan wraps from 2^N-1 to 0.
BUSY  output  1  high in SCAN state.

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values:
  - State IDLE.
  - D all inactive: 0 if ACTIVE_LOW=0, all-ones otherwise.
  - IDX=0, WRAP=0, BUSY=0, dwell counter 0.
- SEL_READY is combinational: EN && !MODE && state!=SCAN.
- Transfer occurs when SEL_VALID && SEL_READY.
- States:
  - IDLE:
    - D inactive.
    - Transfer -> HOLD; IDX=SEL and D=onehot(SEL) on the next edge (1-cycle latency).
    - EN && MODE -> SCAN; IDX=0, D=bit0, dwell loaded from DWELL.
  - HOLD:
    - D=onehot(IDX).
    - A new transfer updates IDX and D on the next edge.
    - MODE=1 -> SCAN starting at current IDX, dwell loaded.
  - SCAN:
    - BUSY=1; SEL_VALID ignored.
    - Dwell counter counts down from the DWELL value latched at each step. At 0, IDX increments modulo 2^N and DWELL is re-sampled.
    - DWELL changes mid-step take effect only at the next step.
    - Wrap 2^N-1 -> 0: WRAP=1 in the same cycle D shows bit0.
    - MODE=0 -> HOLD, freezing the current IDX.
- Priority per cycle: RST > EN=0 > MODE change > transfer/dwell advance.
- EN=0 in any state -> IDLE on the next edge:
  - D inactive, WRAP=0, BUSY=0.
  - IDX retains its value.
  - Dwell counter cleared.
- MODE change and SEL_VALID in the same cycle: SEL_READY depends on MODE, so MODE=1 blocks the transfer.
- DWELL=0: advance every cycle.
- N=1 is legal: 2 outputs.
- Exactly one bit of D is active in HOLD/SCAN; none in IDLE.
- Reset asserted mid-scan clears everything immediately, without waiting for a clock edge.

Optional Feature:
DECODER_SCAN_BLANK_EN
- Defined: each scan step inserts one blank cycle (all D inactive, IDX already updated) before the new line is asserted (break-before-make).
  - Step period becomes DWELL+2 cycles.
  - WRAP pulses in the blank cycle preceding bit0.
  - Entry into SCAN is not blanked.
  - HOLD transitions are not blanked.
- Undefined: no blank cycle; behaviour as in Behaviour.

Test Plan:
- Reset with N=3: assert RST mid-cycle, no clock -> D=8'h00, IDX=0, BUSY=0 immediately. With ACTIVE_LOW=1 -> D=8'hFF.
- Direct loads: EN=1, MODE=0, SEL=5 with VALID for 1 cycle -> next edge D=8'h20, IDX=5. Then SEL=2 -> D=8'h04. Sweep SEL 0..7 -> D=1<<SEL each time.
- Scan with DWELL=0 from IDLE -> D sequence 01,02,04,...,80,01, one per cycle. WRAP high only in the cycle D returns to 01. BUSY=1 throughout.
- Scan with DWELL=3 -> each value held exactly 4 cycles. Change DWELL to 0 mid-step -> current step still lasts 4 cycles, following steps 1.
- Mode/enable interplay:
  - In SCAN at IDX=6, set MODE=0 -> D holds 8'h40.
  - SEL_VALID during SCAN -> SEL_READY=0, no effect.
  - EN=0 -> D=00 next edge, IDX stays 6.
- With DECODER_SCAN_BLANK_EN, DWELL=1 -> per step: 2 cycles active, 1 cycle D=00. Period 3 cycles. WRAP in the blank cycle before 01.
